// File: rtl/debounce_fsm.sv
// Switch debouncer: two-flop synchronizer, shared sample tick, confirm-count FSM.
// Outputs are registered; a level change is accepted after CONFIRM consecutive agreeing ticks.
module debounce_fsm #(
    parameter int TICK_W  = 20,
    parameter int CONFIRM = 3
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sw,
    output logic o_db_lvl,
    output logic o_db_rise,
    output logic o_db_fall,
    output logic o_tick
);

    localparam logic [3:0] CNT_INIT = 4'(CONFIRM - 1);

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } state_t;

    logic              sw_m_q;
    logic              sw_s_q;
    logic [TICK_W-1:0] tick_q;
    logic [TICK_W-1:0] tick_d;
    state_t            state_q;
    logic [3:0]        cnt_q;
    logic              lvl_q;
    logic              rise_q;
    logic              fall_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sw_m_q <= 1'b0;
            sw_s_q <= 1'b0;
        end else begin
            sw_m_q <= i_sw;
            sw_s_q <= sw_m_q;
        end
    end

    // Free-running; never restarted on state entry, so accept latency varies by up to one tick period.
    assign tick_d = tick_q + TICK_W'(1);
    assign o_tick = &tick_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ZERO;
            cnt_q   <= 4'd0;
            lvl_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            unique case (state_q)
                ZERO: begin
                    if (sw_s_q) begin
                        state_q <= WAIT1;
                        cnt_q   <= CNT_INIT;
                    end
                end
                WAIT1: begin
                    // A disagreeing sample wins over a tick landing in the same cycle.
                    if (!sw_s_q) begin
                        state_q <= ZERO;
                    end else if (o_tick) begin
                        if (cnt_q == 4'd0) begin
                            state_q <= ONE;
                            lvl_q   <= 1'b1;
                            rise_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - 4'd1;
                        end
                    end
                end
                ONE: begin
                    if (!sw_s_q) begin
                        state_q <= WAIT0;
                        cnt_q   <= CNT_INIT;
                    end
                end
                WAIT0: begin
                    if (sw_s_q) begin
                        state_q <= ONE;
                    end else if (o_tick) begin
                        if (cnt_q == 4'd0) begin
                            state_q <= ZERO;
                            lvl_q   <= 1'b0;
                            fall_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - 4'd1;
                        end
                    end
                end
                default: begin
                    state_q <= ZERO;
                end
            endcase
        end
    end

    assign o_db_lvl  = lvl_q;
    assign o_db_rise = rise_q;
    assign o_db_fall = fall_q;

endmodule

// File: tb/tb_debounce_fsm.sv
// Bench for debounce_fsm with TICK_W=4, CONFIRM=3: directed scenarios plus random switch
// activity, every cycle compared against a tick-counting reference model.
module tb_debounce_fsm;

    localparam int TICK_W  = 4;
    localparam int CONFIRM = 3;
    localparam int P       = 1 << TICK_W;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    logic i_sw  = 1'b0;
    logic o_db_lvl, o_db_rise, o_db_fall, o_tick;

    debounce_fsm #(.TICK_W(TICK_W), .CONFIRM(CONFIRM)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_sw     (i_sw),
        .o_db_lvl (o_db_lvl),
        .o_db_rise(o_db_rise),
        .o_db_fall(o_db_fall),
        .o_tick   (o_tick)
    );

    always #5 i_clk = ~i_clk;

    int n_vec = 0;
    int n_err = 0;
    int n_rise = 0;
    int n_fall = 0;

    // Reference: cycles since reset, a 2-deep sample history, and the number of
    // ticks seen while the synchronized input disagrees with the accepted level.
    int   m_tc = 0;
    logic m_h1 = 1'b0, m_h2 = 1'b0;
    logic m_lvl = 1'b0, m_rise = 1'b0, m_fall = 1'b0;
    bit   m_inrun = 0;
    int   m_ticks = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic sw, input logic rst);
        logic tick_pre, sws_pre;
        i_sw  = sw;
        i_rst = rst;
        tick_pre = (m_tc == P - 1);
        sws_pre  = m_h2;
        if (rst) begin
            m_tc = 0; m_h1 = 0; m_h2 = 0;
            m_lvl = 0; m_rise = 0; m_fall = 0;
            m_inrun = 0; m_ticks = 0;
        end else begin
            m_rise = 0;
            m_fall = 0;
            if (sws_pre == m_lvl) begin
                m_inrun = 0;
                m_ticks = 0;
            end else if (!m_inrun) begin
                // First disagreeing cycle only opens the run; its tick is not counted.
                m_inrun = 1;
                m_ticks = 0;
            end else if (tick_pre) begin
                m_ticks++;
                if (m_ticks == CONFIRM) begin
                    m_lvl   = sws_pre;
                    m_rise  = sws_pre;
                    m_fall  = !sws_pre;
                    m_inrun = 0;
                    m_ticks = 0;
                end
            end
            m_tc = (m_tc + 1) % P;
            m_h2 = m_h1;
            m_h1 = sw;
        end
        @(posedge i_clk);
        #1;
        check("lvl",  o_db_lvl,  m_lvl);
        check("rise", o_db_rise, m_rise);
        check("fall", o_db_fall, m_fall);
        check("tick", o_tick,    (m_tc == P - 1));
        check("rise_fall_excl", o_db_rise & o_db_fall, 0);
        if (o_db_rise === 1'b1) n_rise++;
        if (o_db_fall === 1'b1) n_fall++;
    endtask

    initial begin
        int lat, r0, f0, last_tick, period, len;
        logic lv, v;

        // Reset state
        repeat (3) step(1'b0, 1'b1);

        // Stable high: latency, single rise pulse, tick period
        r0 = n_rise; lat = -1; last_tick = -1; period = -1;
        for (int k = 1; k <= 80; k++) begin
            step(1'b1, 1'b0);
            if (lat < 0 && o_db_lvl === 1'b1) lat = k;
            if (o_tick === 1'b1) begin
                if (last_tick >= 0) period = k - last_tick;
                last_tick = k;
            end
        end
        check("stable_hi_latency_ok", (lat >= 35 && lat <= 50), 1);
        check("stable_hi_rise_count", n_rise - r0, 1);
        check("tick_period", period, P);

        // Bounce from ONE, then settle low
        f0 = n_fall; lat = -1;
        for (int k = 0; k < 60; k++) step(((k / 3) % 2 == 0) ? 1'b0 : 1'b1, 1'b0);
        for (int k = 1; k <= 80; k++) begin
            step(1'b0, 1'b0);
            if (lat < 0 && o_db_fall === 1'b1) lat = k;
        end
        check("bounce_fall_count", n_fall - f0, 1);
        // Upper bound allows a tick coinciding with the run's opening cycle.
        check("bounce_fall_latency_ok", (lat >= 35 && lat <= 51), 1);

        // Glitch rejection
        r0 = n_rise;
        repeat (5) step(1'b1, 1'b0);
        repeat (60) step(1'b0, 1'b0);
        check("glitch_rise_count", n_rise - r0, 0);
        check("glitch_lvl", o_db_lvl, 0);

        // Tick collision: synchronized input drops exactly in a tick cycle while in WAIT1
        r0 = n_rise;
        repeat (20) step(1'b1, 1'b0);
        for (int k = 0; k < P && m_tc != P - 3; k++) step(1'b1, 1'b0);
        repeat (30) step(1'b0, 1'b0);
        check("collision_rise_count", n_rise - r0, 0);
        check("collision_lvl", o_db_lvl, 0);

        // Reset mid-WAIT0 aborts the pending fall
        repeat (60) step(1'b1, 1'b0);
        check("pre_wait0_lvl", o_db_lvl, 1);
        f0 = n_fall;
        repeat (20) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        check("rst_wait0_lvl", o_db_lvl, 0);
        repeat (60) step(1'b0, 1'b0);
        check("rst_wait0_fall_count", n_fall - f0, 0);

        // Reset released with switch held high qualifies as a normal rise
        r0 = n_rise;
        step(1'b1, 1'b1);
        repeat (60) step(1'b1, 1'b0);
        check("rst_held_hi_rise_count", n_rise - r0, 1);

        // Random switch activity with occasional resets
        lv = 1'b0;
        for (int s = 0; s < 60; s++) begin
            len = $urandom_range(1, 80);
            v = 1'($urandom_range(0, 1));
            lv = v;
            for (int k = 0; k < len; k++) begin
                step(lv, ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
                if ($urandom_range(0, 9) == 0) step(~lv, 1'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
